// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ingress-to-egress FIFO scheduler.
package fifo_rr_scheduler_pkg;

    localparam int N_CH_DEF     = 4;
    localparam int WORD_W_DEF   = 6;
    localparam int UMBRAL_W_DEF = 3;
    // Destination channel lives in the top DEST_W bits of each word
    localparam int DEST_W       = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    function automatic logic [1:0] ch_index(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter; the search starts one past the last granted channel.
module rr_arbiter_4 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] request,
    input  logic       enable,
    output logic [3:0] grant
);

    logic [1:0] last_grant;
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;

    always_comb begin
        grant = '0;
        idx   = '0;
        sel   = last_grant;
        found = 1'b0;
        // k = 4 wraps back to last_grant, so it is searched last
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && enable && request[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (found) grant[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)      last_grant <= 2'd3;
        else if (found) last_grant <= sel;
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains four ingress FIFOs round-robin and routes each word to the egress FIFO
// named by its destination bits; pop-to-push latency is a fixed two cycles.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int UMBRAL_W = UMBRAL_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [UMBRAL_W-1:0]      umbral_ae_in,
    input  logic [UMBRAL_W-1:0]      umbral_af_in,
    input  logic [N_CH-1:0]          fifo_empty,
    input  logic [N_CH-1:0]          fifo_almost_empty,
    input  logic [N_CH*WORD_W-1:0]   fifo_data_in,
    input  logic [N_CH-1:0]          pausa,
    output logic [N_CH-1:0]          pop,
    output logic [N_CH-1:0]          push,
    output logic [WORD_W-1:0]        data_out,
    output logic [UMBRAL_W-1:0]      umbral_ae,
    output logic [UMBRAL_W-1:0]      umbral_af,
    output logic                     active,
    output logic                     idle,
    output logic [1:0]               state
);

    state_t              st, st_n;
    logic [N_CH-1:0]     eligible;
    logic [N_CH-1:0]     grant;
    logic                arb_en;
    logic                rd_vld;
    logic [1:0]          rd_idx;
    logic [WORD_W-1:0]   lane [N_CH];
    logic [WORD_W-1:0]   rd_word;
    logic [DEST_W-1:0]   dest;
    logic [N_CH-1:0]     push_n;
    logic                idle_n;

    assign state = st;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign lane[i] = fifo_data_in[i*WORD_W +: WORD_W];
    end

    // A channel popped this cycle on its last word must not be popped again
    assign eligible = ~fifo_empty & ~(pop & fifo_almost_empty);
    assign arb_en   = (st == ST_ACTIVE) && !init && !(|pausa);

    rr_arbiter_4 u_arb (
        .clk     (clk),
        .reset   (reset),
        .request (eligible),
        .enable  (arb_en),
        .grant   (grant)
    );

    assign rd_word = lane[rd_idx];
    assign dest    = rd_word[WORD_W-1 -: DEST_W];

    always_comb begin
        push_n = '0;
        if (rd_vld) push_n[dest] = 1'b1;
    end

    always_comb begin
        st_n = st;
        case (st)
            ST_INIT:   if (!init) st_n = ST_IDLE;
            ST_IDLE:   if (init) st_n = ST_INIT;
                       else if (!(&fifo_empty)) st_n = ST_ACTIVE;
            ST_ACTIVE: if (init) st_n = ST_INIT;
                       else if (&fifo_empty && !(|grant) && !(|pop) && !rd_vld)
                           st_n = ST_IDLE;
            default:   st_n = ST_INIT;
        endcase
        idle_n = (st_n == ST_IDLE) && (&fifo_empty) && !(|grant) && !(|pop) && !rd_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_INIT;
            pop       <= '0;
            push      <= '0;
            data_out  <= '0;
            umbral_ae <= '0;
            umbral_af <= '0;
            active    <= 1'b0;
            idle      <= 1'b0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
        end else begin
            st       <= st_n;
            pop      <= grant;
            // Read data arrives one cycle after the pop; remember who was popped
            rd_vld   <= |pop;
            rd_idx   <= ch_index(pop);
            push     <= push_n;
            data_out <= rd_vld ? rd_word : '0;
            if (st == ST_INIT) begin
                umbral_ae <= umbral_ae_in;
                umbral_af <= umbral_af_in;
            end
            active   <= (st_n == ST_ACTIVE);
            idle     <= idle_n;
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench with behavioural ingress FIFOs and a push scoreboard.
module tb_fifo_rr_scheduler;
    import fifo_rr_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset, init;
    logic [2:0]  umbral_ae_in, umbral_af_in;
    logic [3:0]  fifo_empty, fifo_almost_empty, pausa;
    logic [23:0] fifo_data_in;
    logic [3:0]  pop, push;
    logic [5:0]  data_out;
    logic [2:0]  umbral_ae, umbral_af;
    logic        active, idle;
    logic [1:0]  state;

    logic [5:0]  rdata [4];
    logic [5:0]  fq [4][$];

    typedef struct {
        int         due;
        logic [5:0] w;
    } exp_t;
    exp_t sb [$];
    int   pop_log [$];
    int   pop_cyc [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    assign fifo_data_in = {rdata[3], rdata[2], rdata[1], rdata[0]};

    fifo_rr_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .init              (init),
        .umbral_ae_in      (umbral_ae_in),
        .umbral_af_in      (umbral_af_in),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_data_in      (fifo_data_in),
        .pausa             (pausa),
        .pop               (pop),
        .push              (push),
        .data_out          (data_out),
        .umbral_ae         (umbral_ae),
        .umbral_af         (umbral_af),
        .active            (active),
        .idle              (idle),
        .state             (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]        = (fq[i].size() == 0);
            fifo_almost_empty[i] = (fq[i].size() <= 1);
        end
    endtask

    task automatic load(input int ch, input logic [5:0] w);
        fq[ch].push_back(w);
        upd();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) if (fq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: apply the FIFO reads the DUT issued, then score the new outputs
    task automatic tick(input bit clr);
        logic [3:0] ps;
        exp_t       e;
        ps = pop;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (ps[i] === 1'b1) begin
                chk("pop_nonempty", fq[i].size() > 0, 1);
                if (fq[i].size() > 0) rdata[i] = fq[i].pop_front();
            end
        end
        upd();
        if (clr) sb.delete();
        if (push !== 4'b0) begin
            if (sb.size() == 0) chk("push_unexpected", push, 0);
            else begin
                e = sb.pop_front();
                chk("push_cycle", cyc, e.due);
                chk("push_vec", push, 4'b0001 << e.w[5:4]);
                chk("data_out", data_out, e.w);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("push_missing", push, 4'b0001 << sb[0].w[5:4]);
            void'(sb.pop_front());
        end
        chk("pop_onehot0", $onehot0(pop), 1);
        for (int i = 0; i < 4; i++) begin
            if (pop[i] === 1'b1 && fq[i].size() > 0) begin
                sb.push_back('{cyc + 2, fq[i][0]});
                pop_log.push_back(i);
                pop_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (!(idle === 1'b1 && sb.size() == 0 && all_empty()) && n < maxc) begin
            tick(0);
            n++;
        end
        chk({tag, "_idle_reached"}, n < maxc, 1);
    endtask

    task automatic wait_pops(input string tag, input int cnt, input int maxc);
        int n;
        n = 0;
        while (pop_log.size() < cnt && n < maxc) begin
            tick(0);
            n++;
        end
        chk({tag, "_pops_seen"}, n < maxc, 1);
    endtask

    initial begin
        int n;
        int last;
        reset = 1'b1; init = 1'b0; pausa = '0;
        umbral_ae_in = '0; umbral_af_in = '0;
        for (int i = 0; i < 4; i++) rdata[i] = '0;
        upd();
        tick(1);
        tick(1);
        chk("rst_state", state, ST_INIT);
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ae", umbral_ae, 0);
        chk("rst_af", umbral_af, 0);
        chk("rst_active", active, 0);
        chk("rst_idle", idle, 0);

        // Threshold distribution
        reset = 1'b0; init = 1'b1; umbral_ae_in = 3'd1; umbral_af_in = 3'd3;
        tick(0);
        tick(0);
        chk("init_state", state, ST_INIT);
        chk("init_ae", umbral_ae, 1);
        chk("init_af", umbral_af, 3);
        init = 1'b0;
        tick(0);
        chk("init_to_idle", state, ST_IDLE);
        chk("idle_flag", idle, 1);
        umbral_ae_in = 3'd5;
        tick(0);
        chk("ae_held_in_idle", umbral_ae, 1);
        umbral_ae_in = 3'd1;

        // Round-robin over four channels, two words each
        pop_log.delete(); pop_cyc.delete();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 2; k++)
                load(ch, {2'(ch + k), 4'(ch * 2 + k)});
        wait_pops("rr", 8, 30);
        run_until_idle("rr", 30);
        chk("rr_count", pop_log.size(), 8);
        for (int k = 0; k < pop_log.size() && k < 8; k++) begin
            chk("rr_order", pop_log[k], k % 4);
            chk("rr_consecutive", pop_cyc[k] - pop_cyc[0], k);
        end

        // Routing by destination bits
        pop_log.delete(); pop_cyc.delete();
        load(2, 6'b11_0101);
        n = 0;
        while (push === 4'b0 && n < 20) begin tick(0); n++; end
        chk("route_seen", n < 20, 1);
        chk("route_push", push, 4'b1000);
        chk("route_data", data_out, 6'h35);
        chk("route_pops", pop_log.size(), 1);
        if (pop_log.size() > 0) begin
            chk("route_pop_ch", pop_log[0], 2);
            chk("route_latency", cyc - pop_cyc[0], 2);
        end
        run_until_idle("route", 20);

        // Back-pressure from one egress FIFO stalls everything
        pop_log.delete(); pop_cyc.delete();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 4; k++)
                load(ch, {2'(3 - k), 4'(ch * 4 + k)});
        wait_pops("pausa", 3, 20);
        pausa = 4'b0010;
        tick(0);
        chk("pausa_pop_stop", pop, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0);
            chk("pausa_pop_held", pop, 0);
        end
        chk("pausa_drained", sb.size(), 0);
        chk("pausa_active", active, 1);
        last = pop_log.size() > 0 ? pop_log[pop_log.size() - 1] : 0;
        pausa = 4'b0000;
        tick(0);
        chk("pausa_resume", pop, 4'b0001 << ((last + 1) % 4));
        run_until_idle("pausa", 80);

        // Last word on a channel: exactly one pop, then back to idle
        pop_log.delete(); pop_cyc.delete();
        load(0, 6'h0A);
        run_until_idle("last", 20);
        chk("last_pops", pop_log.size(), 1);
        chk("last_state", state, ST_IDLE);
        chk("last_idle", idle, 1);

        // Reset in the middle of a stream
        pop_log.delete(); pop_cyc.delete();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 3; k++)
                load(ch, {2'(ch), 4'(k + 8)});
        wait_pops("prerst", 2, 20);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_pop", pop, 0);
        chk("mid_rst_push", push, 0);
        chk("mid_rst_state", state, ST_INIT);
        chk("mid_rst_data", data_out, 0);
        reset = 1'b0;
        pop_log.delete(); pop_cyc.delete();
        wait_pops("postrst", 1, 20);
        if (pop_log.size() > 0) chk("mid_rst_first_grant", pop_log[0], 0);
        run_until_idle("postrst", 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
